spike_dispatcher: RTL and testbench
===================================

SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

Interface
REQ-001 Parameter NUMBER_OF_NEURONS, default 8: width of the local spike vector; legal range 1..64.
REQ-002 Parameter NUMBER_OF_ADDRESS_BITS, default 12: width of the source-address bus.
REQ-003 Parameter IDLE_ADDRESS, default 12'hFFF: value driven on source_address whenever addr_valid is low.
REQ-004 CLK_Dispatch  input  1  single clock; all state updates on rising edge.
REQ-005 RST_Dispatch  input  1  reset, asynchronous, active-high.
REQ-006 timestep_start  input  1  one-cycle pulse; capture spike_vector and begin dispatch.
REQ-007 spike_vector  input  NUMBER_OF_NEURONS  bit i = neuron i fired this timestep.
REQ-008 base_address  input  NUMBER_OF_ADDRESS_BITS  source address of neuron 0; sampled with spike_vector.
REQ-009 addr_ready  input  1  downstream (MAC side) accepts current address.
REQ-010 source_address  output  NUMBER_OF_ADDRESS_BITS  address of the spiking neuron being sent.
REQ-011 addr_valid  output  1  source_address holds a valid spike.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse after the last address of a timestep is accepted.
REQ-014 overrun  output  1  sticky; a timestep_start was lost.

Function
REQ-015 FSM states IDLE, SCAN, SEND, DONE; all outputs registered.
REQ-016 IDLE: on timestep_start, latch spike_vector into remaining and base_address into base, then go to SCAN.
REQ-017 SCAN (one cycle): if remaining is nonzero, load source_address = base + index of lowest set bit of remaining, set addr_valid, go to SEND; if zero, go to DONE.
REQ-018 Latency: timestep_start sampled at edge k gives SCAN during k+1 and addr_valid high after edge k+2.
REQ-019 SEND: hold source_address and addr_valid stable while addr_ready is low; no timeout.
REQ-020 Transfer occurs on an edge with addr_valid and addr_ready both high; the sent bit is cleared from remaining.
REQ-021 After a transfer with bits still remaining: next lowest address is presented on the following cycle with addr_valid high (back-to-back, one address per cycle at full throughput).
REQ-022 After a transfer with no bits remaining: addr_valid low, source_address = IDLE_ADDRESS, go to DONE.
REQ-023 DONE (one cycle): done = 1; go to SCAN if pending is full (loading pending into remaining/base and clearing pending), otherwise go to IDLE.
REQ-024 Ascending order: addresses are sent strictly in ascending neuron index, each set bit exactly once.
REQ-025 Address arithmetic: base + index, truncated to NUMBER_OF_ADDRESS_BITS (wraps modulo 2^bits).
REQ-026 Empty vector: the FSM still passes through SCAN and DONE, so done pulses with no address sent (k+1 SCAN, done high during cycle k+2).
REQ-027 timestep_start while busy: captured into a one-deep pending buffer (vector and base) if the buffer is empty.
REQ-028 timestep_start while busy with pending already full: new data discarded, overrun set to 1; overrun stays set until reset.
REQ-029 A timestep_start arriving in the same cycle as DONE goes to pending; pending is consumed in the same DONE (pending priority unchanged).
REQ-030 addr_ready while addr_valid is low is ignored.

Reset
REQ-031 On RST_Dispatch high, immediately and regardless of clock: state=IDLE, remaining=0, pending empty, addr_valid=0, source_address=IDLE_ADDRESS, busy=0, done=0, overrun=0.
REQ-032 Reset mid-SEND abandons the in-flight timestep; no done pulse is generated for it.
REQ-033 First timestep_start is honoured on the first rising edge after reset deasserts.

Verification
REQ-034 base=12'd0, vector=8'b0000_0111, ready held 1 -> addresses 0,1,2 on consecutive cycles from k+2; done at k+5; busy low at k+6.
REQ-035 base=12'd16, vector=8'b1000_0001, ready low for 3 cycles after first valid -> 16 held stable for 3 cycles, then 23 presented; exactly 2 transfers.
REQ-036 vector=0 -> no addr_valid, done pulses once at k+2, source_address stays 12'hFFF.
REQ-037 base=12'hFFE, vector=8'b0000_1111 -> addresses FFE, FFF, 000, 001 (wrap).
REQ-038 Second start during dispatch (vector 8'b0000_0010, base 0) then third start while pending full -> second timestep sends address 1 after first done; overrun=1; third discarded.
REQ-039 Reset asserted mid-SEND, asynchronously between edges -> addr_valid and busy drop immediately, no done pulse, and a fresh start afterwards behaves as in REQ-034.

Source files
------------

// File: rtl/spike_dispatcher.sv
// Spike dispatcher: captures a timestep's spike vector and streams the source
// address of every set bit, lowest index first, over a valid/ready handshake.
module spike_dispatcher #(
    parameter int NUMBER_OF_NEURONS      = 8,
    parameter int NUMBER_OF_ADDRESS_BITS = 12,
    parameter logic [NUMBER_OF_ADDRESS_BITS-1:0] IDLE_ADDRESS = 12'hFFF
) (
    input  logic                              CLK_Dispatch,
    input  logic                              RST_Dispatch,
    input  logic                              timestep_start,
    input  logic [NUMBER_OF_NEURONS-1:0]      spike_vector,
    input  logic [NUMBER_OF_ADDRESS_BITS-1:0] base_address,
    input  logic                              addr_ready,
    output logic [NUMBER_OF_ADDRESS_BITS-1:0] source_address,
    output logic                              addr_valid,
    output logic                              busy,
    output logic                              done,
    output logic                              overrun
);

    localparam int unsigned N     = NUMBER_OF_NEURONS;
    localparam int unsigned IDX_W = (NUMBER_OF_NEURONS > 1) ? $clog2(NUMBER_OF_NEURONS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                            r_state;
    logic [NUMBER_OF_NEURONS-1:0]      r_remaining;
    logic [NUMBER_OF_ADDRESS_BITS-1:0] r_base;
    logic                              r_pend_valid;
    logic [NUMBER_OF_NEURONS-1:0]      r_pend_vec;
    logic [NUMBER_OF_ADDRESS_BITS-1:0] r_pend_base;
    logic [NUMBER_OF_ADDRESS_BITS-1:0] r_addr;
    logic                              r_valid;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_overrun;

    logic [NUMBER_OF_NEURONS-1:0]      w_rem_after;
    logic [NUMBER_OF_ADDRESS_BITS-1:0] w_addr_scan;
    logic [NUMBER_OF_ADDRESS_BITS-1:0] w_addr_next;
    logic                              w_xfer;
    logic                              w_pend_free;
    logic                              w_direct_load;

    function automatic logic [IDX_W-1:0] f_lowest(input logic [NUMBER_OF_NEURONS-1:0] v);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && v[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Clearing the lowest set bit lets the next address be formed in the same
    // cycle as the transfer, giving one address per cycle at full throughput.
    always_comb begin
        w_rem_after   = r_remaining & (r_remaining - 1'b1);
        w_addr_scan   = r_base + NUMBER_OF_ADDRESS_BITS'(f_lowest(r_remaining));
        w_addr_next   = r_base + NUMBER_OF_ADDRESS_BITS'(f_lowest(w_rem_after));
        w_xfer        = r_valid && addr_ready;
        w_pend_free   = !r_pend_valid || (r_state == S_DONE);
        w_direct_load = (r_state == S_DONE) && !r_pend_valid;
    end

    always_ff @(posedge CLK_Dispatch or posedge RST_Dispatch) begin
        if (RST_Dispatch) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_base       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_vec   <= '0;
            r_pend_base  <= '0;
            r_addr       <= IDLE_ADDRESS;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (timestep_start) begin
                        r_remaining <= spike_vector;
                        r_base      <= base_address;
                        r_busy      <= 1'b1;
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (|r_remaining) begin
                        r_addr  <= w_addr_scan;
                        r_valid <= 1'b1;
                        r_state <= S_SEND;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_remaining <= w_rem_after;
                        if (|w_rem_after) begin
                            r_addr <= w_addr_next;
                        end else begin
                            r_addr  <= IDLE_ADDRESS;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (r_pend_valid) begin
                        r_remaining  <= r_pend_vec;
                        r_base       <= r_pend_base;
                        r_pend_valid <= 1'b0;
                        r_state      <= S_SCAN;
                    end else if (timestep_start) begin
                        r_remaining <= spike_vector;
                        r_base      <= base_address;
                        r_state     <= S_SCAN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // In DONE the pending slot is being vacated, so a start there refills it
            // behind the older entry instead of being flagged as an overrun.
            if (timestep_start && (r_state != S_IDLE) && !w_direct_load) begin
                if (w_pend_free) begin
                    r_pend_vec   <= spike_vector;
                    r_pend_base  <= base_address;
                    r_pend_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign source_address = r_addr;
    assign addr_valid     = r_valid;
    assign busy           = r_busy;
    assign done           = r_done;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: ordering, back-pressure, wrap, empty
// vectors, pending/overrun handling and asynchronous reset mid-transfer.
module tb_spike_dispatcher;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  vec;
    logic [11:0] base;
    logic        ready;
    logic [11:0] addr;
    logic        valid;
    logic        busy;
    logic        done;
    logic        overrun;

    int n_cmp;
    int n_err;
    int n_xfer;
    int xfer_mark;

    spike_dispatcher #(
        .NUMBER_OF_NEURONS      (8),
        .NUMBER_OF_ADDRESS_BITS (12),
        .IDLE_ADDRESS           (12'hFFF)
    ) dut (
        .CLK_Dispatch   (clk),
        .RST_Dispatch   (rst),
        .timestep_start (start),
        .spike_vector   (vec),
        .base_address   (base),
        .addr_ready     (ready),
        .source_address (addr),
        .addr_valid     (valid),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && valid && ready) n_xfer++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Idle-with-no-transfer condition shared by many steps.
    task automatic chk_idle(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_addr"},  32'(addr),  32'hFFF);
        chk({tag, "_busy"},  32'(busy),  32'(exp_busy));
        chk({tag, "_done"},  32'(done),  32'(exp_done));
    endtask

    task automatic chk_send(input string tag, input logic [11:0] exp_addr);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_addr"},  32'(addr),  32'(exp_addr));
        chk({tag, "_done"},  32'(done),  32'd0);
    endtask

    task automatic begin_ts(input logic [7:0] v, input logic [11:0] b);
        start = 1'b1;
        vec   = v;
        base  = b;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        n_xfer = 0;
        rst    = 1'b1;
        start  = 1'b0;
        vec    = '0;
        base   = '0;
        ready  = 1'b1;

        #3;
        chk_idle("reset", 1'b0, 1'b0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        tick();
        rst = 1'b0;

        // Three addresses back-to-back with ready held high.
        tick();
        xfer_mark = n_xfer;
        begin_ts(8'b0000_0111, 12'd0);
        tick(); start = 1'b0;
        chk_idle("t1_scan", 1'b1, 1'b0);
        tick(); chk_send("t1_a0", 12'd0);
        tick(); chk_send("t1_a1", 12'd1);
        tick(); chk_send("t1_a2", 12'd2);
        tick(); chk_idle("t1_done", 1'b1, 1'b1);
        tick(); chk_idle("t1_idle", 1'b0, 1'b0);
        chk("t1_xfers", 32'(n_xfer - xfer_mark), 32'd3);

        // Back-pressure: first address held for three cycles.
        ready     = 1'b0;
        xfer_mark = n_xfer;
        begin_ts(8'b1000_0001, 12'd16);
        tick(); start = 1'b0;
        chk_idle("t2_scan", 1'b1, 1'b0);
        tick(); chk_send("t2_hold0", 12'd16);
        tick(); chk_send("t2_hold1", 12'd16);
        tick(); chk_send("t2_hold2", 12'd16);
        ready = 1'b1;
        tick(); chk_send("t2_a7", 12'd23);
        tick(); chk_idle("t2_done", 1'b1, 1'b1);
        tick(); chk_idle("t2_idle", 1'b0, 1'b0);
        chk("t2_xfers", 32'(n_xfer - xfer_mark), 32'd2);

        // Empty vector still produces a done pulse.
        xfer_mark = n_xfer;
        begin_ts(8'b0000_0000, 12'd5);
        tick(); start = 1'b0;
        chk_idle("t3_scan", 1'b1, 1'b0);
        tick(); chk_idle("t3_done", 1'b1, 1'b1);
        tick(); chk_idle("t3_idle", 1'b0, 1'b0);
        chk("t3_xfers", 32'(n_xfer - xfer_mark), 32'd0);

        // Address wraps modulo 2^12.
        begin_ts(8'b0000_1111, 12'hFFE);
        tick(); start = 1'b0;
        chk_idle("t4_scan", 1'b1, 1'b0);
        tick(); chk_send("t4_a0", 12'hFFE);
        tick(); chk_send("t4_a1", 12'hFFF);
        tick(); chk_send("t4_a2", 12'h000);
        tick(); chk_send("t4_a3", 12'h001);
        tick(); chk_idle("t4_done", 1'b1, 1'b1);
        tick(); chk_idle("t4_idle", 1'b0, 1'b0);

        // Second start goes pending, third is lost and raises overrun.
        xfer_mark = n_xfer;
        begin_ts(8'b0000_0111, 12'h100);
        tick();
        begin_ts(8'b0000_0010, 12'h000);
        chk_idle("t5_scan", 1'b1, 1'b0);
        tick();
        begin_ts(8'b1111_1111, 12'h200);
        chk_send("t5_a0", 12'h100);
        chk("t5_ovr_pre", 32'(overrun), 32'd0);
        tick(); start = 1'b0;
        chk_send("t5_a1", 12'h101);
        chk("t5_ovr_set", 32'(overrun), 32'd1);
        tick(); chk_send("t5_a2", 12'h102);
        tick(); chk_idle("t5_done1", 1'b1, 1'b1);
        tick(); chk_idle("t5_scan2", 1'b1, 1'b0);
        tick(); chk_send("t5_b1", 12'h001);
        tick(); chk_idle("t5_done2", 1'b1, 1'b1);
        tick(); chk_idle("t5_idle", 1'b0, 1'b0);
        chk("t5_ovr_sticky", 32'(overrun), 32'd1);
        chk("t5_xfers", 32'(n_xfer - xfer_mark), 32'd4);

        // Asynchronous reset while an address is waiting for ready.
        ready = 1'b0;
        begin_ts(8'b0000_0011, 12'h040);
        tick(); start = 1'b0;
        tick(); chk_send("t6_a0", 12'h040);
        #2 rst = 1'b1;
        #1;
        chk_idle("t6_rst", 1'b0, 1'b0);
        chk("t6_rst_ovr", 32'(overrun), 32'd0);
        tick();
        chk_idle("t6_rst_hold", 1'b0, 1'b0);

        // Start coincides with reset release and is honoured on the next edge.
        rst       = 1'b0;
        ready     = 1'b1;
        xfer_mark = n_xfer;
        begin_ts(8'b0000_0111, 12'd0);
        tick(); start = 1'b0;
        chk_idle("t7_scan", 1'b1, 1'b0);
        tick(); chk_send("t7_a0", 12'd0);
        tick(); chk_send("t7_a1", 12'd1);
        tick(); chk_send("t7_a2", 12'd2);
        tick(); chk_idle("t7_done", 1'b1, 1'b1);
        tick(); chk_idle("t7_idle", 1'b0, 1'b0);
        chk("t7_xfers", 32'(n_xfer - xfer_mark), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
